// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one shared single-transaction resource to N requesters.
// The grant is held until done or the watchdog fires, then re-arbitrated with no idle cycle.
module rr_bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter int IdxW    = (N == 1) ? 1 : $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    localparam int CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLim = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [IdxW-1:0] r_last;
    logic [CntW-1:0] r_cnt;
    logic [N-1:0]    r_grant;
    logic [IdxW-1:0] r_grant_idx;
    logic            r_grant_valid;
    logic            r_timeout;

    logic            w_any;
    logic [IdxW-1:0] w_win_idx;
    logic [N-1:0]    w_win_onehot;
    logic            w_limit;
    logic            w_release;

    // Rotating-priority search: walk from last+N down to last+1 so the nearest
    // requester after last overwrites any farther one.
    always_comb begin
        w_any        = 1'b0;
        w_win_idx    = '0;
        w_win_onehot = '0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = int'(r_last) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (req[j]) begin
                w_any        = 1'b1;
                w_win_idx    = IdxW'(j);
                w_win_onehot = '0;
                w_win_onehot[j] = 1'b1;
            end else begin
                w_any = w_any;
            end
        end
    end

    // Release condition: done, or the watchdog reaching its last allowed cycle.
    always_comb begin
        w_limit   = (TIMEOUT != 0) && (r_cnt == CntLim);
        w_release = done || w_limit;
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last        <= LastRst;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state       <= S_GRANT;
                        r_grant       <= w_win_onehot;
                        r_grant_idx   <= w_win_idx;
                        r_grant_valid <= 1'b1;
                        r_last        <= w_win_idx;
                        r_cnt         <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_timeout <= w_limit && !done;
                        if (w_any) begin
                            r_state       <= S_GRANT;
                            r_grant       <= w_win_onehot;
                            r_grant_idx   <= w_win_idx;
                            r_grant_valid <= 1'b1;
                            r_last        <= w_win_idx;
                            r_cnt         <= '0;
                        end else begin
                            r_state       <= S_IDLE;
                            r_grant       <= '0;
                            r_grant_idx   <= '0;
                            r_grant_valid <= 1'b0;
                            r_cnt         <= '0;
                        end
                    end else begin
                        r_timeout <= 1'b0;
                        r_cnt     <= r_cnt + CntW'(1);
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_last        <= LastRst;
                    r_cnt         <= '0;
                    r_grant       <= '0;
                    r_grant_idx   <= '0;
                    r_grant_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: one instance with an 8-cycle watchdog,
// one with the watchdog disabled, driven from shared inputs.
module tb_rr_bus_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       done;

    logic [3:0] a_grant;
    logic [1:0] a_idx;
    logic       a_valid;
    logic       a_timeout;
    logic [3:0] b_grant;
    logic [1:0] b_idx;
    logic       b_valid;
    logic       b_timeout;

    int checks = 0;
    int errors = 0;

    rr_bus_arbiter #(.N(4), .TIMEOUT(8)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (a_grant),
        .grant_idx   (a_idx),
        .grant_valid (a_valid),
        .timeout     (a_timeout)
    );

    rr_bus_arbiter #(.N(4), .TIMEOUT(0)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (b_grant),
        .grant_idx   (b_idx),
        .grant_valid (b_valid),
        .timeout     (b_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic v, input logic t);
        chk({tag, ".grant"}, 32'(a_grant), 32'(g));
        chk({tag, ".idx"}, 32'(a_idx), 32'(idx));
        chk({tag, ".valid"}, 32'(a_valid), 32'(v));
        chk({tag, ".timeout"}, 32'(a_timeout), 32'(t));
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        step();
        step();
        chk_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset_b.valid", 32'(b_valid), 32'd0);
        reset = 1'b0;

        // 1: full rotation with done every grant cycle
        req = 4'b1111;
        step();
        chk_a("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_a("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        chk_a("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        chk_a("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        chk_a("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_a("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: single requester re-granted back to back
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("solo", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        req = 4'b0000;
        step();
        chk_a("solo_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 3: grant held after req drops, until done
        done = 1'b0;
        req  = 4'b0010;
        step();
        chk_a("hold0", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_a("hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        chk_a("hold2", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_a("hold_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: watchdog forces release after exactly 8 cycles
        done = 1'b0;
        req  = 4'b0011;
        step();
        for (int i = 0; i < 8; i++) begin
            chk_a("wd0", 4'b0001, 2'd0, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk_a("wd1", 4'b0010, 2'd1, 1'b1, (i == 0) ? 1'b1 : 1'b0);
            step();
        end
        chk_a("wd2", 4'b0001, 2'd0, 1'b1, 1'b1);

        // 5a: done coincides with the watchdog limit, so no timeout pulse
        for (int i = 0; i < 7; i++) begin
            step();
            chk_a("lim_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        chk_a("lim_done", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_a("lim_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("b_idle.valid", 32'(b_valid), 32'd0);

        // 5b: watchdog disabled holds the grant indefinitely
        done = 1'b0;
        req  = 4'b0001;
        for (int i = 0; i < 120; i++) begin
            step();
            chk("nowd.grant", 32'(b_grant), 32'h1);
            chk("nowd.timeout", 32'(b_timeout), 32'h0);
        end

        // 6: reset mid-grant with done high, then pointer restarts at N-1
        reset = 1'b1;
        done  = 1'b1;
        req   = 4'b1010;
        step();
        chk_a("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("rst_mid_b.grant", 32'(b_grant), 32'h0);
        reset = 1'b0;
        done  = 1'b0;
        step();
        chk_a("post_rst0", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_a("post_rst1", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_a("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter that shares one single-transaction resource (for example the FPU/memory port) among `N` requesters. It uses the team's rotating-priority tree encoding to pick one winner. It holds a one-hot grant until the resource signals `done` or a watchdog timeout fires. It then re-arbitrates without a bubble cycle. It sits between the requesters' `req` lines and the shared resource's start/done handshake.

## Interface
Parameters:
- `N`, default 4: number of requesters; must be ≥ 1.
- `TIMEOUT`, default 16: maximum grant length in cycles. 0 disables the watchdog.
- `IdxW`, default `N == 1 ? 1 : $clog2(N)`: width of the index fields.

Ports:
- `clock`  in  1  — system clock. Only clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `req`  in  N  — level requests, one per requester. May change on any cycle.
- `done`  in  1  — the resource has finished the current transaction. Sampled only while `grant_valid`.
- `grant`  out  N  — registered one-hot grant; all zeros when idle.
- `grant_idx`  out  IdxW  — binary index of the granted requester. Equals 0 when idle.
- `grant_valid`  out  1  — equals `|grant`.
- `timeout`  out  1  — one-cycle pulse; the previous grant was force-released by the watchdog.

## Operation
- State machine with two states:
  - IDLE: `grant_valid` = 0.
  - GRANT: exactly one `grant` bit set.
- Registers:
  - state.
  - `last` (IdxW), the most recently granted index.
  - watchdog counter `cnt`, width `$clog2(TIMEOUT+1)`, minimum 1.
- Rotating priority: given `last = L`, the search order is `L+1, L+2, …, N-1, 0, …, L`.
  - The winner is the first index in that order whose `req` bit is set.
  - Index arithmetic is modulo `N`.
- IDLE behaviour:
  - If `|req`, the next state is GRANT with `grant` = one-hot(winner), `grant_idx` = winner, `last` ← winner, `cnt` ← 0.
  - Otherwise stay IDLE.
  - `done` is ignored in IDLE.
- GRANT, release condition: release = `done` OR (`TIMEOUT != 0` AND `cnt == TIMEOUT-1`).
- GRANT, no release:
  - Hold `grant`/`grant_idx` unchanged, even if the granted `req` bit drops.
  - `cnt` ← `cnt`+1.
- GRANT, release:
  - Re-arbitrate in the same cycle using current `req` and `last`.
  - If a winner exists, the next state is GRANT with the new winner (possibly the same requester), `last` ← winner, `cnt` ← 0. There is no idle cycle.
  - If no winner, go to IDLE with all grant outputs 0.
- The just-released requester is lowest priority in the re-arbitration, because `last` equals its index.
- `timeout` ← 1 on the release edge only when release was caused by the watchdog and `done` = 0. Otherwise `timeout` ← 0.
- `done` and the watchdog limit on the same cycle: `done` wins, and no `timeout` pulse is generated.
- `N == 1`:
  - Degenerates to grant/hold/release of requester 0.
  - `last` is constant 0.

## Timing
- Reset values: state IDLE, `grant` 0, `grant_idx` 0, `grant_valid` 0, `timeout` 0, `last` = `N-1` (so index 0 has first priority), `cnt` 0.
- Reset during GRANT: outputs reach their reset values at the next edge. `done` in that cycle has no effect.
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `grant` visible after edge k.
- A grant lasts at least 1 cycle.
- `done` sampled at an edge ends that grant at the same edge; the next grant or idle is visible after that edge.
- With the watchdog enabled, a grant is held for exactly `TIMEOUT` cycles if `done` never arrives.
- `timeout` is high for the single cycle following the forced release, coincident with the new grant or with idle.
- All outputs are registered; there is no combinational path from `req`/`done` to outputs.

## Test plan
1. N=4, TIMEOUT=8; reset, then `req`=4'b1111 held, `done` pulsed every grant cycle → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, `grant_idx` 0,1,2,3,0, never idle.
2. `req`=4'b0100 only, `done` high every cycle → `grant` stays 0100 every cycle with no bubble; `grant_valid` continuously 1.
3. `req`=4'b0010 for one cycle then 0, `done` after 3 cycles → `grant`=0010 held 3 cycles despite `req` low, then `grant`=0, `grant_valid`=0.
4. TIMEOUT=8, `req`=4'b0011 held, `done` never → requester 0 granted 8 cycles, then `grant`=0010 with `timeout`=1 for one cycle; after 8 more cycles back to 0001 with `timeout`=1.
5. `done` asserted on the 8th cycle of a grant (watchdog limit) → release with `timeout`=0; TIMEOUT=0 with no `done` → grant held 100+ cycles, no `timeout`.
6. `reset` asserted mid-grant with `done`=1 in the same cycle → next cycle all outputs 0; after release, `req`=4'b1010 → first grant 0010 (pointer back to N-1).
